// File: rtl/max_return_counter.sv
// Per-axis peak tracker: records the brightest ADC sample of a servo sweep,
// counts steps taken since that peak, then requests return steps back to it.
module max_return_counter #(
  parameter int unsigned CNT_W  = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HYST   = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STEP_EN,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              ADC_VALID,
  input  logic              MC,
  input  logic              RET_STEP,
  output logic              CNT_RU,
  output logic              DONE,
  output logic [DATA_W-1:0] MAX_VAL,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF
);

  localparam int unsigned CMP_W = DATA_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SWEEP  = 2'd1;
  localparam logic [1:0] S_RETURN = 2'd2;
  localparam logic [1:0] S_FIN    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              ovf_q, ovf_d;
  logic              cnt_ru_q, cnt_ru_d;
  logic              done_q, done_d;
  logic              new_peak_c;

  // Threshold is widened by one bit so MAX_VAL+HYST can never wrap.
  always_comb begin
    new_peak_c = ADC_VALID &&
                 ({1'b0, ADC_DATA} > ({1'b0, max_q} + CMP_W'(HYST)));
  end

  // Next-state, counter and peak update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    if (START) begin
      state_d = S_SWEEP;
      count_d = '0;
      max_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_SWEEP: begin
          if (new_peak_c) begin
            // Sample belongs to the pre-step position, so a concurrent step counts as one.
            max_d   = ADC_DATA;
            count_d = STEP_EN ? CNT_W'(1) : '0;
          end else if (STEP_EN) begin
            if (count_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
          if (MC) begin
            state_d = (count_d != '0) ? S_RETURN : S_FIN;
          end
        end
        S_RETURN: begin
          if (RET_STEP) begin
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state_d = S_FIN;
            end
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    cnt_ru_d = (state_d == S_RETURN);
    done_d   = (state_d == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_ru_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
      cnt_ru_q <= cnt_ru_d;
      done_q   <= done_d;
    end
  end

  assign CNT_RU  = cnt_ru_q;
  assign DONE    = done_q;
  assign MAX_VAL = max_q;
  assign COUNT   = count_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_max_return_counter.sv
// Directed bench for max_return_counter: three instances (default, HYST=4, CNT_W=3)
// share stimulus; expected outputs are queued per step and checked after the edge.
module tb_max_return_counter;

  logic       CLK, RESET, START, STEP_EN, ADC_VALID, MC, RET_STEP;
  logic [7:0] ADC_DATA;

  logic       ru0, dn0, ov0, ru1, dn1, ov1, ru2, dn2, ov2;
  logic [7:0] mx0, mx1, mx2;
  logic [8:0] cnt0, cnt1;
  logic [2:0] cnt2;

  max_return_counter #(.CNT_W(9), .DATA_W(8), .HYST(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .START(START), .STEP_EN(STEP_EN), .ADC_DATA(ADC_DATA),
    .ADC_VALID(ADC_VALID), .MC(MC), .RET_STEP(RET_STEP), .CNT_RU(ru0), .DONE(dn0),
    .MAX_VAL(mx0), .COUNT(cnt0), .OVF(ov0));

  max_return_counter #(.CNT_W(9), .DATA_W(8), .HYST(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START), .STEP_EN(STEP_EN), .ADC_DATA(ADC_DATA),
    .ADC_VALID(ADC_VALID), .MC(MC), .RET_STEP(RET_STEP), .CNT_RU(ru1), .DONE(dn1),
    .MAX_VAL(mx1), .COUNT(cnt1), .OVF(ov1));

  max_return_counter #(.CNT_W(3), .DATA_W(8), .HYST(0)) dut2 (
    .CLK(CLK), .RESET(RESET), .START(START), .STEP_EN(STEP_EN), .ADC_DATA(ADC_DATA),
    .ADC_VALID(ADC_VALID), .MC(MC), .RET_STEP(RET_STEP), .CNT_RU(ru2), .DONE(dn2),
    .MAX_VAL(mx2), .COUNT(cnt2), .OVF(ov2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int          sel;
    int          fld;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [15:0] get(input int sel, input int fld);
    logic        r_ru, r_dn, r_ov;
    logic [7:0]  r_mx;
    logic [15:0] r_cnt;
    case (sel)
      1:       begin r_ru = ru1; r_dn = dn1; r_ov = ov1; r_mx = mx1; r_cnt = 16'(cnt1); end
      2:       begin r_ru = ru2; r_dn = dn2; r_ov = ov2; r_mx = mx2; r_cnt = 16'(cnt2); end
      default: begin r_ru = ru0; r_dn = dn0; r_ov = ov0; r_mx = mx0; r_cnt = 16'(cnt0); end
    endcase
    case (fld)
      0:       get = 16'(r_ru);
      1:       get = 16'(r_dn);
      2:       get = 16'(r_mx);
      3:       get = r_cnt;
      default: get = 16'(r_ov);
    endcase
  endfunction

  // Queue expected CNT_RU, DONE, MAX_VAL, COUNT, OVF of one instance for the next edge.
  task automatic ex(input int sel, input logic ru, input logic dn, input logic [7:0] mx,
                    input int cnt, input logic ov, input string tag);
    sbq.push_back('{{tag, ".cnt_ru"}, sel, 0, 16'(ru)});
    sbq.push_back('{{tag, ".done"},   sel, 1, 16'(dn)});
    sbq.push_back('{{tag, ".max_val"}, sel, 2, 16'(mx)});
    sbq.push_back('{{tag, ".count"},  sel, 3, 16'(cnt)});
    sbq.push_back('{{tag, ".ovf"},    sel, 4, 16'(ov)});
  endtask

  task automatic chk();
    exp_t        e;
    logic [15:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      obs = get(e.sel, e.fld);
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s dut%0d observed=%0h expected=%0h", e.tag, e.sel, obs, e.val);
      end
    end
  endtask

  // Drive one cycle of inputs, clock, then compare everything queued.
  task automatic step(input logic s, input logic st, input logic v, input logic [7:0] d,
                      input logic m, input logic r);
    START = s; STEP_EN = st; ADC_VALID = v; ADC_DATA = d; MC = m; RET_STEP = r;
    @(posedge CLK);
    #1;
    START = 1'b0; STEP_EN = 1'b0; ADC_VALID = 1'b0; ADC_DATA = 8'h00; MC = 1'b0; RET_STEP = 1'b0;
    chk();
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0; STEP_EN = 1'b0; ADC_VALID = 1'b0; ADC_DATA = 8'h00; MC = 1'b0; RET_STEP = 1'b0;
    step(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) ex(i, 0, 0, 8'h00, 0, 0, "reset");
    step(0, 0, 0, 8'h00, 0, 0);
    RESET = 1'b0;

    // Basic sweep and return
    ex(0, 0, 0, 8'h00, 0, 0, "b_start");   step(1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 0, 0, 8'h00, 2, 0, "b_pre");     step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 0, 0, 8'h40, 0, 0, "b_peak");    step(0, 0, 1, 8'h40, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 0, 0, 8'h40, 2, 0, "b_lowsmp");  step(0, 1, 1, 8'h30, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 0, 0, 8'h40, 4, 0, "b_cnt4");    step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 1, 0, 8'h40, 4, 0, "b_mc");      step(0, 0, 0, 8'h00, 1, 0);
    ex(0, 1, 0, 8'h40, 4, 0, "b_ign");     step(0, 1, 1, 8'hff, 1, 0);
    ex(0, 1, 0, 8'h40, 3, 0, "b_ret1");    step(0, 0, 0, 8'h00, 0, 1);
    ex(0, 1, 0, 8'h40, 3, 0, "b_gap");     step(0, 0, 0, 8'h00, 0, 0);
    ex(0, 1, 0, 8'h40, 2, 0, "b_ret2");    step(0, 0, 0, 8'h00, 0, 1);
    ex(0, 1, 0, 8'h40, 1, 0, "b_ret3");    step(0, 0, 0, 8'h00, 0, 1);
    ex(0, 0, 1, 8'h40, 0, 0, "b_done");    step(0, 0, 0, 8'h00, 0, 1);
    ex(0, 0, 0, 8'h40, 0, 0, "b_idle");    step(0, 0, 0, 8'h00, 0, 0);
    ex(0, 0, 0, 8'h40, 0, 0, "b_idle_in"); step(0, 1, 1, 8'hff, 1, 1);

    // Peak on final sample, MC in the same cycle
    ex(0, 0, 0, 8'h00, 0, 0, "p_start");   step(1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 1, 8'h10, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    step(0, 0, 1, 8'h20, 0, 0);
    ex(0, 0, 0, 8'h20, 1, 0, "p_step");    step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 0, 1, 8'h30, 0, 0, "p_mc");      step(0, 0, 1, 8'h30, 1, 0);
    ex(0, 0, 0, 8'h30, 0, 0, "p_after");   step(0, 0, 0, 8'h00, 0, 0);

    // Hysteresis on dut1, dut0 as HYST=0 reference
    ex(1, 0, 0, 8'h00, 0, 0, "h_start");   step(1, 0, 0, 8'h00, 0, 0);
    ex(1, 0, 0, 8'h50, 0, 0, "h_peak");    step(0, 0, 1, 8'h50, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    ex(1, 0, 0, 8'h50, 2, 0, "h_cnt2");    step(0, 1, 0, 8'h00, 0, 0);
    ex(1, 0, 0, 8'h50, 2, 0, "h_53");
    ex(0, 0, 0, 8'h53, 0, 0, "h0_53");     step(0, 0, 1, 8'h53, 0, 0);
    ex(1, 0, 0, 8'h50, 3, 0, "h_54edge");  step(0, 1, 1, 8'h54, 0, 0);
    ex(1, 0, 0, 8'h55, 0, 0, "h_55");      step(0, 0, 1, 8'h55, 0, 0);

    // Saturation on dut2
    ex(2, 0, 0, 8'h00, 0, 0, "s_start");   step(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 8'h00, 0, 0);
    ex(2, 0, 0, 8'h00, 7, 1, "s_sat");     step(0, 1, 0, 8'h00, 0, 0);
    ex(2, 1, 0, 8'h00, 7, 1, "s_mc");      step(0, 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 0, 1);
    ex(2, 1, 0, 8'h00, 1, 1, "s_ret6");    step(0, 0, 0, 8'h00, 0, 1);
    ex(2, 0, 1, 8'h00, 0, 1, "s_done");    step(0, 0, 0, 8'h00, 0, 1);
    ex(2, 0, 0, 8'h00, 0, 1, "s_hold");    step(0, 0, 0, 8'h00, 0, 0);
    ex(2, 0, 0, 8'h00, 0, 0, "s_clr");     step(1, 0, 0, 8'h00, 0, 0);

    // Simultaneous peak+step, MC with final step
    ex(0, 0, 0, 8'h00, 0, 0, "x_start");   step(1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 0, 0, 8'h20, 1, 0, "x_pk_step"); step(0, 1, 1, 8'h20, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 1, 0, 8'h20, 3, 0, "x_mc_step"); step(0, 1, 0, 8'h00, 1, 0);

    // Abort during RETURN
    ex(0, 0, 0, 8'h00, 0, 0, "a_start");   step(1, 0, 0, 8'h00, 0, 0);
    ex(0, 0, 0, 8'h00, 0, 0, "a_nodone");  step(0, 0, 0, 8'h00, 0, 0);

    // Reset mid-sweep, then MC must be ignored
    step(0, 1, 0, 8'h00, 0, 0);
    ex(0, 0, 0, 8'h33, 0, 0, "r_peak");    step(0, 0, 1, 8'h33, 0, 0);
    ex(0, 0, 0, 8'h33, 1, 0, "r_step");    step(0, 1, 0, 8'h00, 0, 0);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) ex(i, 0, 0, 8'h00, 0, 0, "r_reset");
    step(0, 1, 1, 8'hff, 1, 0);
    RESET = 1'b0;
    ex(0, 0, 0, 8'h00, 0, 0, "r_mc1");     step(0, 0, 0, 8'h00, 1, 0);
    ex(0, 0, 0, 8'h00, 0, 0, "r_mc2");     step(0, 1, 1, 8'h77, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
